// File: rtl/blk_assemble_pkg.sv
//------------------------------------------------------------------------------
// Module   : blk_assemble_pkg
// Purpose  : Shared constants, state encoding and helpers for the SHA-256
//            block assembler (message bit-length width, block geometry,
//            accumulator depth, MSB helper).
// Ports    : none (package)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package blk_assemble_pkg;

   // Message byte count width (total is PROCB_TOTAL_MSB+1 bits)
   localparam int PROCB_TOTAL_MSB = 31;

   // 32-bit words per 64-byte SHA-256 block
   localparam int BLK_WORDS = 16;

   // Largest number of bytes the accumulator may hold between words
   localparam int ACC_BYTES_MAX = 7;

   // Assembler states
   localparam logic [0:0] S_RUN = 1'b0;
   localparam logic [0:0] S_ERR = 1'b1;

   // Index of the highest set bit; 0 for a zero argument
   function automatic int msb(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if (value[i]) r = i;
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/blk_assemble_byte_extract.sv
//------------------------------------------------------------------------------
// Module   : blk_assemble_byte_extract
// Purpose  : Combinational byte source for one command: picks memory bytes,
//            padding bytes or the big-endian message bit length, and flags
//            illegal length/offset combinations.
// Ports    : mem_dout/len/off/add0x80pad/add0pad/add_total/total - command
//            bytes_out - up to 4 bytes, stream byte k in bits [8k+7:8k]
//            byte_cnt  - number of valid bytes (0..4)
//            bad       - command cannot be honoured
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module blk_assemble_byte_extract
   import blk_assemble_pkg::*;
(
   input  logic [31:0]              mem_dout,
   input  logic [2:0]               len,
   input  logic [1:0]               off,
   input  logic                     add0x80pad,
   input  logic                     add0pad,
   input  logic                     add_total,
   input  logic [PROCB_TOTAL_MSB:0] total,
   output logic [31:0]              bytes_out,
   output logic [2:0]               byte_cnt,
   output logic                     bad
);

   logic [31:0] w_bitlen;
   logic [31:0] w_shift;
   logic [3:0]  w_end;

   // Bit length is the byte count times 8, only the low 32 bits are sent
   assign w_bitlen = 32'({total, 3'b000});
   assign w_shift  = mem_dout >> {off, 3'b000};
   assign w_end    = {2'b00, off} + {1'b0, len};

   always_comb begin
      bytes_out = '0;
      byte_cnt  = len;
      bad       = 1'b0;
      if (add_total) begin
         // Stream order is MSB first
         byte_cnt  = 3'd4;
         bytes_out = {w_bitlen[7:0], w_bitlen[15:8], w_bitlen[23:16], w_bitlen[31:24]};
      end else if (add0x80pad) begin
         bad       = (len > 3'd4);
         bytes_out = (len != 3'd0) ? 32'h0000_0080 : 32'h0;
      end else if (add0pad) begin
         bad       = (len > 3'd4);
      end else begin
         bad = (len > 3'd4) || (w_end > 4'd4);
         for (int k = 0; k < 4; k++) begin
            if (3'(k) < len) bytes_out[8*k +: 8] = w_shift[8*k +: 8];
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/blk_assemble.sv
//------------------------------------------------------------------------------
// Module   : blk_assemble
// Purpose  : Packs byte-granular commands (memory bytes, padding, bit length)
//            into big-endian 32-bit SHA-256 message words, 16 per block, with
//            block-end alignment checking and a sticky error flag.
// Ports    : CLK, RST_N (async, active-low)
//            in_en, mem_dout, len, off, add0x80pad, add0pad, add_total,
//            total, blk_end, in_thread_num - command inputs
//            out_wr_en, out_data, out_word_num, out_thread_num - word output
//            blk_ready - pulse with word 15, err - sticky error
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module blk_assemble
   import blk_assemble_pkg::*;
#(
   parameter int N_THREADS     = -1,
   parameter int N_THREADS_MSB = msb(N_THREADS - 1)
)(
   input  logic                     CLK,
   input  logic                     RST_N,
   input  logic                     in_en,
   input  logic [31:0]              mem_dout,
   input  logic [2:0]               len,
   input  logic [1:0]               off,
   input  logic                     add0x80pad,
   input  logic                     add0pad,
   input  logic                     add_total,
   input  logic [PROCB_TOTAL_MSB:0] total,
   input  logic                     blk_end,
   input  logic [N_THREADS_MSB:0]   in_thread_num,
   output logic                     out_wr_en,
   output logic [31:0]              out_data,
   output logic [3:0]               out_word_num,
   output logic [N_THREADS_MSB:0]   out_thread_num,
   output logic                     blk_ready,
   output logic                     err
);

   localparam int c_COMB_BYTES = ACC_BYTES_MAX + 4;

   logic [0:0]                   r_state;
   logic [0:0]                   w_next_state;
   logic [ACC_BYTES_MAX*8-1:0]   r_acc;
   logic [2:0]                   r_acc_cnt;
   logic [3:0]                   r_word_cnt;

   logic [31:0]                  w_new_bytes;
   logic [2:0]                   w_new_cnt;
   logic                         w_bad;
   logic [c_COMB_BYTES*8-1:0]    w_comb;
   logic [3:0]                   w_tot;
   logic                         w_emit;
   logic                         w_blk_ok;
   logic                         w_take;
   logic                         w_fault;

   blk_assemble_byte_extract u_byte_extract (
      .mem_dout   (mem_dout),
      .len        (len),
      .off        (off),
      .add0x80pad (add0x80pad),
      .add0pad    (add0pad),
      .add_total  (add_total),
      .total      (total),
      .bytes_out  (w_new_bytes),
      .byte_cnt   (w_new_cnt),
      .bad        (w_bad)
   );

   // Pending bytes followed by the new ones; byte 0 is the oldest
   always_comb begin
      w_comb = {32'h0, r_acc};
      for (int k = 0; k < 4; k++) begin
         if (3'(k) < w_new_cnt) w_comb[8*(int'(r_acc_cnt) + k) +: 8] = w_new_bytes[8*k +: 8];
      end
   end

   assign w_tot    = {1'b0, r_acc_cnt} + {1'b0, w_new_cnt};
   assign w_emit   = (w_tot >= 4'd4);
   // A block may only close on an exact word boundary at word 15
   assign w_blk_ok = (w_tot == 4'd4) && (r_word_cnt == 4'(BLK_WORDS - 1));

   // FSM: state register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) r_state <= S_RUN;
      else        r_state <= w_next_state;
   end

   // FSM: next state
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_RUN:   if (w_fault) w_next_state = S_ERR;
         S_ERR:   if (in_en && blk_end) w_next_state = S_RUN;
         default: w_next_state = S_RUN;
      endcase
   end

   // FSM: outputs
   always_comb begin
      w_take  = 1'b0;
      w_fault = 1'b0;
      case (r_state)
         S_RUN: begin
            if (in_en) begin
               if (w_bad || (blk_end && !w_blk_ok)) w_fault = 1'b1;
               else                                 w_take  = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Accumulator, word counter and output registers
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_acc          <= '0;
         r_acc_cnt      <= 3'd0;
         r_word_cnt     <= 4'd0;
         out_wr_en      <= 1'b0;
         out_data       <= 32'h0;
         out_word_num   <= 4'd0;
         out_thread_num <= '0;
         blk_ready      <= 1'b0;
         err            <= 1'b0;
      end else begin
         out_wr_en <= 1'b0;
         blk_ready <= 1'b0;
         if ((r_state == S_RUN) && in_en && (r_word_cnt == 4'd0) && (r_acc_cnt == 3'd0))
            out_thread_num <= in_thread_num;
         if (w_fault) begin
            err        <= 1'b1;
            r_acc      <= '0;
            r_acc_cnt  <= 3'd0;
            r_word_cnt <= 4'd0;
         end
         if (w_take) begin
            if (w_emit) begin
               out_wr_en    <= 1'b1;
               out_data     <= {w_comb[7:0], w_comb[15:8], w_comb[23:16], w_comb[31:24]};
               out_word_num <= r_word_cnt;
               r_word_cnt   <= r_word_cnt + 4'd1;
               blk_ready    <= blk_end;
               r_acc        <= w_comb[32 +: ACC_BYTES_MAX*8];
               r_acc_cnt    <= 3'(w_tot - 4'd4);
            end else begin
               r_acc        <= w_comb[ACC_BYTES_MAX*8-1:0];
               r_acc_cnt    <= w_tot[2:0];
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_blk_assemble.sv
//------------------------------------------------------------------------------
// Module   : tb_blk_assemble
// Purpose  : Self-checking bench for blk_assemble: byte-queue reference model
//            compared every cycle, plus literal expectations per scenario.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_blk_assemble;
   import blk_assemble_pkg::*;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        in_en;
   logic [31:0] mem_dout;
   logic [2:0]  len;
   logic [1:0]  off;
   logic        add0x80pad, add0pad, add_total;
   logic [31:0] total;
   logic        blk_end;
   logic [1:0]  in_thread_num;
   logic        out_wr_en;
   logic [31:0] out_data;
   logic [3:0]  out_word_num;
   logic [1:0]  out_thread_num;
   logic        blk_ready;
   logic        err;

   always #5 CLK = ~CLK;

   blk_assemble #(.N_THREADS(4)) dut (
      .CLK(CLK), .RST_N(RST_N), .in_en(in_en), .mem_dout(mem_dout), .len(len), .off(off),
      .add0x80pad(add0x80pad), .add0pad(add0pad), .add_total(add_total), .total(total),
      .blk_end(blk_end), .in_thread_num(in_thread_num), .out_wr_en(out_wr_en),
      .out_data(out_data), .out_word_num(out_word_num), .out_thread_num(out_thread_num),
      .blk_ready(blk_ready), .err(err)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, expv);
      end
   endtask

   // ---------------- reference model: byte queue per block ----------------
   logic [7:0]  m_q[$];
   logic [7:0]  m_b[4];
   int          m_n, m_p, m_wi = 0;
   bit          m_bad;
   logic [31:0] m_bitlen;
   logic [1:0]  m_thr = 2'd0;
   logic        m_err = 1'b0, m_drop = 1'b0;
   logic        exp_wr = 1'b0, exp_rdy = 1'b0;
   logic [31:0] exp_data = 32'h0;
   logic [3:0]  exp_wn = 4'd0;

   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         m_q.delete();
         m_wi = 0; m_thr = 2'd0; m_err = 1'b0; m_drop = 1'b0;
         exp_wr = 1'b0; exp_rdy = 1'b0; exp_data = 32'h0; exp_wn = 4'd0;
      end else begin
         exp_wr  = 1'b0;
         exp_rdy = 1'b0;
         if (in_en) begin
            if (m_drop) begin
               if (blk_end) m_drop = 1'b0;
            end else begin
               if (m_q.size() == 0 && m_wi == 0) m_thr = in_thread_num;
               m_bad = 1'b0;
               m_n   = 0;
               if (add_total) begin
                  m_bitlen = total * 8;
                  m_b[0] = m_bitlen[31:24]; m_b[1] = m_bitlen[23:16];
                  m_b[2] = m_bitlen[15:8];  m_b[3] = m_bitlen[7:0];
                  m_n = 4;
               end else if (len > 3'd4) begin
                  m_bad = 1'b1;
               end else begin
                  m_n = int'(len);
                  for (int k = 0; k < m_n; k++) begin
                     if (add0x80pad)   m_b[k] = (k == 0) ? 8'h80 : 8'h00;
                     else if (add0pad) m_b[k] = 8'h00;
                     else begin
                        m_p = int'(off) + k;
                        if (m_p > 3) m_bad = 1'b1;
                        else         m_b[k] = mem_dout[8*m_p +: 8];
                     end
                  end
               end
               if (!m_bad) for (int k = 0; k < m_n; k++) m_q.push_back(m_b[k]);
               if (m_bad || (blk_end && !(m_q.size() == 4 && m_wi == 15))) begin
                  m_err = 1'b1; m_drop = 1'b1; m_q.delete(); m_wi = 0;
               end else if (m_q.size() >= 4) begin
                  exp_data = {m_q[0], m_q[1], m_q[2], m_q[3]};
                  repeat (4) void'(m_q.pop_front());
                  exp_wr  = 1'b1;
                  exp_wn  = 4'(m_wi);
                  exp_rdy = blk_end;
                  m_wi    = (m_wi + 1) % 16;
               end
            end
         end
      end
   end

   // ---------------- per-cycle compare + word log ----------------
   logic [31:0] log_data[16];
   int          n_words = 0;
   int          n_rdy   = 0;

   always @(negedge CLK) begin
      if (RST_N) begin
         chk("wr_en", out_wr_en, exp_wr);
         chk("blk_ready", blk_ready, exp_rdy);
         chk("err", err, m_err);
         if (exp_wr && out_wr_en) begin
            chk("data", out_data, exp_data);
            chk("word_num", out_word_num, exp_wn);
            chk("thread", out_thread_num, m_thr);
         end
         if (out_wr_en) begin
            log_data[out_word_num] = out_data;
            n_words++;
            if (blk_ready) n_rdy++;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(input logic [31:0] m, input logic [2:0] l, input logic [1:0] o,
                       input logic p80, input logic p0, input logic at,
                       input logic [31:0] tt, input logic be);
      @(negedge CLK);
      in_en = 1'b1; mem_dout = m; len = l; off = o;
      add0x80pad = p80; add0pad = p0; add_total = at; total = tt; blk_end = be;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge CLK);
         in_en = 1'b0; blk_end = 1'b0;
      end
   endtask

   task automatic clr_log();
      n_words = 0;
      n_rdy   = 0;
      for (int i = 0; i < 16; i++) log_data[i] = 32'hDEAD_BEEF;
   endtask

   task automatic aligned(input int gaps, input int ncmd);
      for (int k = 0; k < ncmd; k++) begin
         send(32'h0302_0100 + k * 32'h0404_0404, 3'd4, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0, k == 15);
         if (gaps != 0 && $urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
      end
      idle(2);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      #2;
      RST_N = 1'b0; in_en = 1'b0; blk_end = 1'b0;
      #1;
      chk("rst_wr_en", out_wr_en, 32'h0);
      chk("rst_data", out_data, 32'h0);
      chk("rst_word_num", out_word_num, 32'h0);
      chk("rst_thread", out_thread_num, 32'h0);
      chk("rst_blk_ready", blk_ready, 32'h0);
      chk("rst_err", err, 32'h0);
      @(negedge CLK);
      RST_N = 1'b1;
   endtask

   initial begin
      RST_N = 1'b0; in_en = 1'b0; mem_dout = 32'h0; len = 3'd0; off = 2'd0;
      add0x80pad = 1'b0; add0pad = 1'b0; add_total = 1'b0; total = 32'h0;
      blk_end = 1'b0; in_thread_num = 2'd0;
      repeat (3) @(negedge CLK);
      chk("reset_wr_en", out_wr_en, 32'h0);
      chk("reset_err", err, 32'h0);
      chk("reset_word_num", out_word_num, 32'h0);
      chk("reset_data", out_data, 32'h0);
      RST_N = 1'b1;

      // Aligned block
      in_thread_num = 2'd2;
      clr_log();
      aligned(0, 16);
      chk("aligned_words", n_words, 32'd16);
      chk("aligned_ready", n_rdy, 32'd1);
      chk("aligned_word0", log_data[0], 32'h0001_0203);
      chk("aligned_word15", log_data[15], 32'h3C3D_3E3F);

      // Same block with idle gaps
      in_thread_num = 2'd1;
      clr_log();
      aligned(1, 16);
      chk("gaps_words", n_words, 32'd16);
      chk("gaps_ready", n_rdy, 32'd1);
      for (int j = 0; j < 16; j++) chk("gaps_word", log_data[j], 32'h0001_0203 + j * 32'h0404_0404);

      // Reset after word 6, then a new block starts at word 0
      clr_log();
      aligned(0, 7);
      chk("mid_words", n_words, 32'd7);
      chk("mid_word6", log_data[6], 32'h1819_1A1B);
      do_reset();
      in_thread_num = 2'd3;
      clr_log();
      send(32'hDDCC_BBAA, 3'd3, 2'd1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      send(32'h0000_00EE, 3'd1, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      idle(2);
      chk("unaligned_words", n_words, 32'd1);
      chk("unaligned_word0", log_data[0], 32'hBBCC_DDEE);

      // Padding and bit length of a 5-byte message
      do_reset();
      in_thread_num = 2'd0;
      clr_log();
      send(32'h0403_0201, 3'd4, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      send(32'h0000_0005, 3'd1, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      send(32'h0, 3'd3, 2'd0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 13; i++) send(32'h0, 3'd4, 2'd0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      send(32'h0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1, 32'd5, 1'b1);
      idle(2);
      chk("pad_words", n_words, 32'd16);
      chk("pad_ready", n_rdy, 32'd1);
      chk("pad_word0", log_data[0], 32'h0102_0304);
      chk("pad_word1", log_data[1], 32'h0580_0000);
      chk("pad_word14", log_data[14], 32'h0);
      chk("pad_word15", log_data[15], 32'h0000_0028);
      chk("pad_err", err, 32'h0);

      // Misaligned block end, then a dropped block, then recovery
      clr_log();
      send(32'h0302_0100, 3'd4, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      send(32'h0000_0504, 3'd2, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      idle(2);
      chk("misalign_err", err, 32'h1);
      chk("misalign_ready", n_rdy, 32'd0);
      aligned(0, 16);
      chk("dropped_words", n_words, 32'd1);
      chk("dropped_ready", n_rdy, 32'd0);
      aligned(0, 16);
      chk("recover_words", n_words, 32'd17);
      chk("recover_ready", n_rdy, 32'd1);
      chk("recover_word15", log_data[15], 32'h3C3D_3E3F);
      chk("sticky_err", err, 32'h1);

      // Illegal offset+length and illegal length
      do_reset();
      send(32'h1234_5678, 3'd3, 2'd2, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      idle(2);
      chk("offlen_err", err, 32'h1);
      do_reset();
      send(32'h0, 3'd5, 2'd0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      idle(2);
      chk("len5_err", err, 32'h1);
      do_reset();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
